// File: rtl/axi_wr_native_bridge.sv
// AXI4 write slave that replays each accepted W beat as one native write
// request (held until acked) and returns a single B response per burst.
module axi_wr_native_bridge #(
  parameter int unsigned DATA_WIDTH = 128,
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned ID_WIDTH   = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [ID_WIDTH-1:0]     awid,
  input  logic [ADDR_WIDTH-1:0]   awaddr,
  input  logic [7:0]              awlen,
  input  logic [2:0]              awsize,
  input  logic [1:0]              awburst,
  input  logic                    awvalid,
  output logic                    awready,
  input  logic [DATA_WIDTH-1:0]   wdata,
  input  logic [DATA_WIDTH/8-1:0] wstrb,
  input  logic                    wlast,
  input  logic                    wvalid,
  output logic                    wready,
  output logic [ID_WIDTH-1:0]     bid,
  output logic [1:0]              bresp,
  output logic                    bvalid,
  input  logic                    bready,
  output logic [31:0]             wr_addr,
  output logic                    wr_addr_en,
  output logic [DATA_WIDTH-1:0]   wr_data,
  output logic [DATA_WIDTH/8-1:0] wr_datamask,
  output logic                    wr_en,
  input  logic                    wr_busy,
  input  logic                    wr_ack
);

  localparam int unsigned STRB_WIDTH = DATA_WIDTH / 8;
  localparam int unsigned BEAT_BYTES = 16;
  localparam int unsigned OFF_WIDTH  = 14;
  localparam logic [2:0]  BEAT_SIZE  = 3'd4;
  localparam logic [1:0]  BURST_INCR = 2'b01;
  localparam logic [1:0]  RESP_OKAY  = 2'b00;
  localparam logic [1:0]  RESP_SLV   = 2'b10;

  typedef enum logic [2:0] {
    IDLE,
    DATA,
    WAIT_ACK,
    DRAIN,
    RESP
  } state_e;

  state_e                  state_q, state_d;
  logic [ID_WIDTH-1:0]     id_q, id_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [7:0]              len_q, len_d;
  logic [1:0]              burst_q, burst_d;
  logic [7:0]              beat_q, beat_d;
  logic                    err_q, err_d;
  logic                    wr_en_q, wr_en_d;
  logic [31:0]             wr_addr_q, wr_addr_d;
  logic [DATA_WIDTH-1:0]   wr_data_q, wr_data_d;
  logic [STRB_WIDTH-1:0]   wr_mask_q, wr_mask_d;

  logic [OFF_WIDTH-1:0]    span_c;
  logic [OFF_WIDTH-1:0]    end_off_c;
  logic                    illegal_c;
  logic                    last_beat_c;

  // Burst legality: 16-byte beats, FIXED/INCR only, INCR must stay inside a 4 KB page
  always_comb begin
    span_c      = OFF_WIDTH'((OFF_WIDTH'(awlen) + OFF_WIDTH'(1)) << 4);
    end_off_c   = OFF_WIDTH'(awaddr[11:0]) + span_c;
    illegal_c   = (awsize != BEAT_SIZE) || awburst[1] ||
                  ((awburst == BURST_INCR) && (end_off_c > OFF_WIDTH'(4096)));
    last_beat_c = (beat_q == len_q);
  end

  // State and datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      id_q      <= '0;
      addr_q    <= '0;
      len_q     <= '0;
      burst_q   <= '0;
      beat_q    <= '0;
      err_q     <= 1'b0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      wr_mask_q <= '1;
    end else begin
      state_q   <= state_d;
      id_q      <= id_d;
      addr_q    <= addr_d;
      len_q     <= len_d;
      burst_q   <= burst_d;
      beat_q    <= beat_d;
      err_q     <= err_d;
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
      wr_mask_q <= wr_mask_d;
    end
  end

  // Next-state and datapath update
  always_comb begin
    state_d   = state_q;
    id_d      = id_q;
    addr_d    = addr_q;
    len_d     = len_q;
    burst_d   = burst_q;
    beat_d    = beat_q;
    err_d     = err_q;
    wr_en_d   = wr_en_q;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    wr_mask_d = wr_mask_q;

    case (state_q)
      IDLE: begin
        if (awvalid) begin
          id_d    = awid;
          addr_d  = awaddr;
          len_d   = awlen;
          burst_d = awburst;
          beat_d  = '0;
          err_d   = 1'b0;
          state_d = illegal_c ? DRAIN : DATA;
        end
      end
      DATA: begin
        if (wvalid && !wr_busy) begin
          wr_data_d = wdata;
          wr_mask_d = ~wstrb;
          wr_addr_d = 32'(addr_q);
          wr_en_d   = 1'b1;
          // A misplaced wlast is reported but never shortens the burst
          if (wlast != last_beat_c) begin
            err_d = 1'b1;
          end
          state_d = WAIT_ACK;
        end
      end
      WAIT_ACK: begin
        if (wr_ack) begin
          wr_en_d = 1'b0;
          beat_d  = 8'(beat_q + 8'd1);
          if (burst_q == BURST_INCR) begin
            addr_d = addr_q + ADDR_WIDTH'(BEAT_BYTES);
          end
          state_d = last_beat_c ? RESP : DATA;
        end
      end
      DRAIN: begin
        if (wvalid) begin
          beat_d = 8'(beat_q + 8'd1);
          if (last_beat_c) begin
            err_d   = 1'b1;
            state_d = RESP;
          end
        end
      end
      RESP: begin
        if (bready) begin
          err_d   = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Channel handshakes decode the registered state; wready follows native backpressure
  assign awready     = (state_q == IDLE);
  assign wready      = ((state_q == DATA) && !wr_busy) || (state_q == DRAIN);
  assign bvalid      = (state_q == RESP);
  assign bid         = id_q;
  assign bresp       = ((state_q == RESP) && err_q) ? RESP_SLV : RESP_OKAY;
  assign wr_en       = wr_en_q;
  assign wr_addr_en  = wr_en_q;
  assign wr_addr     = wr_addr_q;
  assign wr_data     = wr_data_q;
  assign wr_datamask = wr_mask_q;

endmodule

// File: tb/tb_axi_wr_native_bridge.sv
// Bench for axi_wr_native_bridge: directed scenarios plus randomized bursts
// checked against a burst-level reference model of the native write stream.
module tb_axi_wr_native_bridge;

  localparam int unsigned DW = 128;
  localparam int unsigned AW = 32;
  localparam int unsigned IW = 8;
  localparam int unsigned SW = DW / 8;

  logic          clk, rst;
  logic [IW-1:0] awid;
  logic [AW-1:0] awaddr;
  logic [7:0]    awlen;
  logic [2:0]    awsize;
  logic [1:0]    awburst;
  logic          awvalid, awready;
  logic [DW-1:0] wdata;
  logic [SW-1:0] wstrb;
  logic          wlast, wvalid, wready;
  logic [IW-1:0] bid;
  logic [1:0]    bresp;
  logic          bvalid, bready;
  logic [31:0]   wr_addr;
  logic          wr_addr_en;
  logic [DW-1:0] wr_data;
  logic [SW-1:0] wr_datamask;
  logic          wr_en, wr_busy, wr_ack;

  typedef struct { logic [31:0] a; logic [DW-1:0] d; logic [SW-1:0] m; } nat_t;
  typedef struct { logic [DW-1:0] d; logic [SW-1:0] s; logic l; } wbeat_t;

  nat_t   obs_q[$];
  nat_t   exp_q[$];
  wbeat_t wb_q[$];
  logic [1:0]    exp_bresp;
  logic [IW-1:0] got_bid;
  logic [1:0]    got_bresp;
  int checks   = 0;
  int failures = 0;
  int ack_dly  = 2;
  bit rand_busy  = 0;
  bit spurious   = 0;
  bit busy_force = 0;

  axi_wr_native_bridge #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .ID_WIDTH(IW)) dut (
    .clk(clk), .rst(rst),
    .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
    .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
    .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready),
    .wr_addr(wr_addr), .wr_addr_en(wr_addr_en), .wr_data(wr_data),
    .wr_datamask(wr_datamask), .wr_en(wr_en), .wr_busy(wr_busy), .wr_ack(wr_ack)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation still running at %0t, required to finish", $time);
    $fatal(1, "watchdog");
  end

  // Native controller model: logs each new request, checks hold/drop rules, acks after ack_dly
  initial begin : native_side
    int   cnt;
    bit   prev_en, prev_ack;
    nat_t prev, cur;
    cnt = 0; prev_en = 0; prev_ack = 0;
    wr_ack = 1'b0; wr_busy = 1'b0;
    forever begin
      @(negedge clk);
      cur.a = wr_addr; cur.d = wr_data; cur.m = wr_datamask;
      checks++;
      if (wr_addr_en !== wr_en) begin
        failures++;
        $display("FAIL addr_en_tracks_en: wr_addr_en=%b wr_en=%b required equal", wr_addr_en, wr_en);
      end
      if (wr_en === 1'b1) begin
        if (!prev_en) begin
          obs_q.push_back(cur);
        end else begin
          checks++;
          if (prev_ack) begin
            failures++;
            $display("FAIL en_drop_after_ack: wr_en=1 required 0 in cycle after ack");
          end else if (cur.a !== prev.a || cur.d !== prev.d || cur.m !== prev.m) begin
            failures++;
            $display("FAIL req_stable: addr=%h mask=%h required addr=%h mask=%h", cur.a, cur.m, prev.a, prev.m);
          end
        end
        cnt++;
        wr_ack = (cnt >= ack_dly);
        if (wr_ack) cnt = 0;
      end else begin
        cnt = 0;
        wr_ack = spurious && ($urandom_range(0, 2) == 0);
      end
      wr_busy  = busy_force || (rand_busy && ($urandom_range(0, 3) == 0));
      prev_en  = (wr_en === 1'b1);
      prev_ack = wr_ack && (wr_en === 1'b1);
      prev     = cur;
    end
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic send_aw(input logic [IW-1:0] id, input logic [AW-1:0] a, input logic [7:0] len,
                         input logic [2:0] sz, input logic [1:0] bu);
    int n;
    awid = id; awaddr = a; awlen = len; awsize = sz; awburst = bu; awvalid = 1'b1;
    n = 0;
    while (awready !== 1'b1 && n < 200) begin tick(); n++; end
    checks++;
    if (n >= 200) begin failures++; $display("FAIL aw_timeout: awready=%b required 1", awready); end
    tick();
    awvalid = 1'b0;
  endtask

  task automatic send_w(input wbeat_t b);
    int n;
    wdata = b.d; wstrb = b.s; wlast = b.l; wvalid = 1'b1;
    n = 0;
    while (wready !== 1'b1 && n < 200) begin tick(); n++; end
    checks++;
    if (n >= 200) begin failures++; $display("FAIL w_timeout: wready=%b required 1", wready); end
    tick();
    wvalid = 1'b0;
  endtask

  task automatic wait_b();
    int n;
    n = 0;
    while (bvalid !== 1'b1 && n < 400) begin tick(); n++; end
    checks++;
    if (n >= 400) begin failures++; $display("FAIL b_timeout: bvalid=%b required 1", bvalid); end
    got_bid = bid; got_bresp = bresp;
  endtask

  task automatic b_accept();
    bready = 1'b1;
    tick();
    bready = 1'b0;
  endtask

  task automatic gen_beats(input int len, input int bad, input bit rs, input logic [SW-1:0] fs);
    wbeat_t b;
    wb_q.delete();
    for (int i = 0; i <= len; i++) begin
      b.d = {$urandom, $urandom, $urandom, $urandom};
      b.s = rs ? SW'($urandom) : fs;
      b.l = (i == len) ^ (i == bad);
      wb_q.push_back(b);
    end
  endtask

  task automatic run_burst(input logic [IW-1:0] id, input logic [AW-1:0] a, input logic [7:0] len,
                           input logic [2:0] sz, input logic [1:0] bu, input int gap_max);
    obs_q.delete();
    send_aw(id, a, len, sz, bu);
    foreach (wb_q[i]) begin
      repeat ($urandom_range(0, gap_max)) tick();
      send_w(wb_q[i]);
    end
    wait_b();
  endtask

  // Reference: legal bursts write every beat at base(+16*i for INCR), mask=~strb; else nothing
  task automatic model(input logic [AW-1:0] a, input int len, input logic [2:0] sz, input logic [1:0] bu);
    int   off;
    bit   legal, err;
    nat_t n;
    off   = int'(a[11:0]);
    legal = (sz == 3'd4) && (bu == 2'b00 || bu == 2'b01) && !(bu == 2'b01 && off + 16 * (len + 1) > 4096);
    exp_q.delete();
    if (!legal) begin
      exp_bresp = 2'b10;
    end else begin
      err = 0;
      for (int i = 0; i <= len; i++) begin
        n.a = (bu == 2'b01) ? a + 32'(16 * i) : a;
        n.d = wb_q[i].d;
        n.m = ~wb_q[i].s;
        if (wb_q[i].l != (i == len)) err = 1;
        exp_q.push_back(n);
      end
      exp_bresp = err ? 2'b10 : 2'b00;
    end
  endtask

  task automatic test_reset();
    tick(); tick();
    checks++;
    if (awready !== 1'b1 || wready !== 1'b0 || bvalid !== 1'b0) begin
      failures++;
      $display("FAIL reset_handshakes: awready=%b wready=%b bvalid=%b required 1 0 0", awready, wready, bvalid);
    end
    checks++;
    if (wr_en !== 1'b0 || wr_addr_en !== 1'b0 || bid !== 8'h00 || bresp !== 2'b00) begin
      failures++;
      $display("FAIL reset_ctrl: wr_en=%b wr_addr_en=%b bid=%h bresp=%b required 0 0 00 00", wr_en, wr_addr_en, bid, bresp);
    end
    checks++;
    if (wr_addr !== 32'h0 || wr_data !== '0 || wr_datamask !== 16'hFFFF) begin
      failures++;
      $display("FAIL reset_data: wr_addr=%h wr_data=%h mask=%h required 0 0 ffff", wr_addr, wr_data, wr_datamask);
    end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_incr();
    bit p_en;
    int n;
    ack_dly = 2;
    gen_beats(3, -1, 0, 16'h00FF);
    obs_q.delete();
    send_aw(8'd4, 32'h100, 8'd3, 3'd4, 2'b01);
    checks++;
    if (wready !== 1'b1 || awready !== 1'b0) begin
      failures++;
      $display("FAIL incr_aw_latency: wready=%b awready=%b required 1 0", wready, awready);
    end
    for (int i = 0; i < 4; i++) begin
      send_w(wb_q[i]);
      checks++;
      if (wr_en !== 1'b1 || wready !== 1'b0) begin
        failures++;
        $display("FAIL incr_w_latency beat%0d: wr_en=%b wready=%b required 1 0", i, wr_en, wready);
      end
    end
    n = 0; p_en = 1'b1;
    while (bvalid !== 1'b1 && n < 50) begin p_en = (wr_en === 1'b1); tick(); n++; end
    checks++;
    if (bvalid !== 1'b1 || wr_en !== 1'b0 || p_en !== 1'b1) begin
      failures++;
      $display("FAIL incr_ack_to_bvalid: bvalid=%b wr_en=%b en_before=%b required 1 0 1", bvalid, wr_en, p_en);
    end
    checks++;
    if (obs_q.size() != 4) begin
      failures++;
      $display("FAIL incr_count: got %0d native writes required 4", obs_q.size());
    end else begin
      foreach (obs_q[i]) begin
        checks++;
        if (obs_q[i].a !== 32'h100 + 32'(16 * i) || obs_q[i].m !== 16'hFF00 || obs_q[i].d !== wb_q[i].d) begin
          failures++;
          $display("FAIL incr_beat%0d: addr=%h mask=%h required addr=%h mask=ff00", i, obs_q[i].a, obs_q[i].m, 32'h100 + 32'(16 * i));
        end
      end
    end
    checks++;
    if (bid !== 8'd4 || bresp !== 2'b00) begin
      failures++;
      $display("FAIL incr_b: bid=%h bresp=%b required 04 00", bid, bresp);
    end
    tick(); tick();
    checks++;
    if (bvalid !== 1'b1 || awready !== 1'b0) begin
      failures++;
      $display("FAIL incr_b_hold: bvalid=%b awready=%b required 1 0", bvalid, awready);
    end
    b_accept();
    checks++;
    if (bvalid !== 1'b0 || awready !== 1'b1) begin
      failures++;
      $display("FAIL incr_b_done: bvalid=%b awready=%b required 0 1", bvalid, awready);
    end
  endtask

  task automatic test_4k_cross();
    gen_beats(1, -1, 1, '0);
    run_burst(8'h21, 32'h0000_0FF0, 8'd1, 3'd4, 2'b01, 1);
    checks++;
    if (obs_q.size() != 0 || got_bresp !== 2'b10 || got_bid !== 8'h21) begin
      failures++;
      $display("FAIL cross4k: writes=%0d bresp=%b bid=%h required 0 10 21", obs_q.size(), got_bresp, got_bid);
    end
    b_accept();
    gen_beats(1, -1, 1, '0);
    run_burst(8'h22, 32'h0000_1FE0, 8'd1, 3'd4, 2'b01, 1);
    checks++;
    if (obs_q.size() != 2 || got_bresp !== 2'b00) begin
      failures++;
      $display("FAIL fit4k: writes=%0d bresp=%b required 2 00", obs_q.size(), got_bresp);
    end else begin
      checks++;
      if (obs_q[0].a !== 32'h1FE0 || obs_q[1].a !== 32'h1FF0) begin
        failures++;
        $display("FAIL fit4k_addr: addr0=%h addr1=%h required 1fe0 1ff0", obs_q[0].a, obs_q[1].a);
      end
    end
    b_accept();
  endtask

  task automatic test_busy();
    busy_force = 1'b1;
    tick();
    gen_beats(1, -1, 1, '0);
    obs_q.delete();
    wdata = wb_q[0].d; wstrb = wb_q[0].s; wlast = wb_q[0].l; wvalid = 1'b1;
    send_aw(8'h33, 32'h0000_3000, 8'd1, 3'd4, 2'b01);
    wvalid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      checks++;
      if (wready !== 1'b0 || wr_en !== 1'b0) begin
        failures++;
        $display("FAIL busy_wready cycle%0d: wready=%b wr_en=%b required 0 0", i, wready, wr_en);
      end
      tick();
    end
    busy_force = 1'b0;
    send_w(wb_q[0]);
    send_w(wb_q[1]);
    wait_b();
    model(32'h0000_3000, 1, 3'd4, 2'b01);
    checks++;
    if (obs_q.size() != exp_q.size() || got_bresp !== exp_bresp || got_bid !== 8'h33) begin
      failures++;
      $display("FAIL busy_burst: writes=%0d bresp=%b bid=%h required %0d %b 33", obs_q.size(), got_bresp, got_bid, exp_q.size(), exp_bresp);
    end else begin
      foreach (exp_q[i]) begin
        checks++;
        if (obs_q[i].a !== exp_q[i].a || obs_q[i].d !== exp_q[i].d || obs_q[i].m !== exp_q[i].m) begin
          failures++;
          $display("FAIL busy_beat%0d: addr=%h mask=%h required addr=%h mask=%h", i, obs_q[i].a, obs_q[i].m, exp_q[i].a, exp_q[i].m);
        end
      end
    end
    b_accept();
  endtask

  task automatic test_wlast_err();
    gen_beats(2, 1, 1, '0);
    run_burst(8'h55, 32'h0000_4000, 8'd2, 3'd4, 2'b01, 0);
    checks++;
    if (obs_q.size() != 3 || got_bresp !== 2'b10) begin
      failures++;
      $display("FAIL early_wlast: writes=%0d bresp=%b required 3 10", obs_q.size(), got_bresp);
    end else begin
      foreach (obs_q[i]) begin
        checks++;
        if (obs_q[i].a !== 32'h4000 + 32'(16 * i) || obs_q[i].d !== wb_q[i].d) begin
          failures++;
          $display("FAIL early_wlast_beat%0d: addr=%h required %h", i, obs_q[i].a, 32'h4000 + 32'(16 * i));
        end
      end
    end
    b_accept();
    gen_beats(1, 1, 1, '0);
    run_burst(8'h56, 32'h0000_4800, 8'd1, 3'd4, 2'b01, 0);
    checks++;
    if (obs_q.size() != 2 || got_bresp !== 2'b10) begin
      failures++;
      $display("FAIL missing_wlast: writes=%0d bresp=%b required 2 10", obs_q.size(), got_bresp);
    end
    b_accept();
  endtask

  task automatic test_reset_mid();
    int n;
    ack_dly = 2;
    gen_beats(3, -1, 1, '0);
    obs_q.delete();
    send_aw(8'h66, 32'h0000_5000, 8'd3, 3'd4, 2'b01);
    send_w(wb_q[0]);
    n = 0;
    while (wr_en !== 1'b0 && n < 50) begin tick(); n++; end
    ack_dly = 1000;
    send_w(wb_q[1]);
    tick(); tick();
    checks++;
    if (wr_en !== 1'b1 || wr_addr !== 32'h5010) begin
      failures++;
      $display("FAIL rstmid_pre: wr_en=%b wr_addr=%h required 1 5010", wr_en, wr_addr);
    end
    rst = 1'b1;
    tick();
    checks++;
    if (wr_en !== 1'b0 || wr_addr_en !== 1'b0 || awready !== 1'b1 || bvalid !== 1'b0 || wready !== 1'b0) begin
      failures++;
      $display("FAIL rstmid_after: wr_en=%b addr_en=%b awready=%b bvalid=%b wready=%b required 0 0 1 0 0",
               wr_en, wr_addr_en, awready, bvalid, wready);
    end
    rst = 1'b0;
    ack_dly = 2;
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++;
      if (bvalid !== 1'b0) begin failures++; $display("FAIL rstmid_no_b: bvalid=%b required 0", bvalid); end
    end
    gen_beats(0, -1, 1, '0);
    run_burst(8'h67, 32'h0000_6000, 8'd0, 3'd4, 2'b01, 0);
    checks++;
    if (obs_q.size() != 1 || got_bresp !== 2'b00 || got_bid !== 8'h67) begin
      failures++;
      $display("FAIL rstmid_next: writes=%0d bresp=%b bid=%h required 1 00 67", obs_q.size(), got_bresp, got_bid);
    end else begin
      checks++;
      if (obs_q[0].a !== 32'h6000 || obs_q[0].d !== wb_q[0].d) begin
        failures++;
        $display("FAIL rstmid_next_beat: addr=%h required 6000", obs_q[0].a);
      end
    end
    b_accept();
  endtask

  task automatic test_random();
    logic [IW-1:0] id;
    logic [7:0]    len;
    logic [AW-1:0] a;
    logic [2:0]    sz;
    logic [1:0]    bu;
    int            r, bad;
    rand_busy = 1'b1;
    spurious  = 1'b1;
    for (int it = 0; it < 40; it++) begin
      id  = IW'($urandom);
      len = 8'($urandom_range(0, 7));
      if ($urandom_range(0, 9) == 0) len = 8'($urandom_range(8, 31));
      a = $urandom;
      if ($urandom_range(0, 2) == 0) a[11:0] = 12'(4096 - 16 * $urandom_range(1, 10));
      sz = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(0, 7)) : 3'd4;
      r  = $urandom_range(0, 19);
      bu = (r < 6) ? 2'b00 : (r < 17) ? 2'b01 : 2'($urandom_range(2, 3));
      bad = ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, int'(len))) : -1;
      ack_dly = $urandom_range(1, 4);
      gen_beats(int'(len), bad, 1, '0);
      run_burst(id, a, len, sz, bu, 2);
      model(a, int'(len), sz, bu);
      checks++;
      if (obs_q.size() != exp_q.size() || got_bresp !== exp_bresp || got_bid !== id) begin
        failures++;
        $display("FAIL rand%0d_burst: writes=%0d bresp=%b bid=%h required %0d %b %h", it,
                 obs_q.size(), got_bresp, got_bid, exp_q.size(), exp_bresp, id);
      end else begin
        foreach (exp_q[i]) begin
          checks++;
          if (obs_q[i].a !== exp_q[i].a || obs_q[i].d !== exp_q[i].d || obs_q[i].m !== exp_q[i].m) begin
            failures++;
            $display("FAIL rand%0d_beat%0d: addr=%h mask=%h required addr=%h mask=%h", it, i,
                     obs_q[i].a, obs_q[i].m, exp_q[i].a, exp_q[i].m);
          end
        end
      end
      repeat ($urandom_range(0, 3)) tick();
      checks++;
      if (bvalid !== 1'b1 || bresp !== exp_bresp) begin
        failures++;
        $display("FAIL rand%0d_b_hold: bvalid=%b bresp=%b required 1 %b", it, bvalid, bresp, exp_bresp);
      end
      b_accept();
    end
    rand_busy = 1'b0;
    spurious  = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    awid = '0; awaddr = '0; awlen = '0; awsize = '0; awburst = '0; awvalid = 1'b0;
    wdata = '0; wstrb = '0; wlast = 1'b0; wvalid = 1'b0;
    bready = 1'b0;
    test_reset();
    test_incr();
    test_4k_cross();
    test_busy();
    test_wlast_err();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
